// File: rtl/lo_simulate_core.sv
// LF (125 kHz) tag-simulation front end: ADC clock/capture, SSP serializer,
// load modulation. Optional hysteresis comparator on dbg: LO_SIM_HYST_EN.
// Ports: pck0/rst clock+sync reset; adc_d sample in; ssp_dout/cross_lo mod in;
// adc_clk, ssp_clk/frame/din, pwr_lo/hi, pwr_oe1..4, dbg out.
module lo_simulate_core #(
  parameter int unsigned CLK_DIV   = 5,
  parameter int unsigned THRESH_HI = 200
) (
  input  logic       pck0,
  input  logic       rst,
  input  logic       ck_1356meg,
  input  logic       ck_1356megb,
  input  logic [7:0] adc_d,
  input  logic       ssp_dout,
  input  logic       cross_hi,
  input  logic       cross_lo,
  output logic       adc_clk,
  output logic       ssp_frame,
  output logic       ssp_din,
  output logic       ssp_clk,
  output logic       pwr_lo,
  output logic       pwr_hi,
  output logic       pwr_oe1,
  output logic       pwr_oe2,
  output logic       pwr_oe3,
  output logic       pwr_oe4,
  output logic       dbg
);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  localparam logic [7:0] DIV_MAX = CLK_DIV[7:0];
  localparam logic [7:0] TH_SET  = THRESH_HI[7:0];
  localparam logic [7:0] TH_CLR  = 8'(255 - THRESH_HI);

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic       adc_clk_q, adc_clk_d;
  logic [7:0] sample_q, sample_d;
  logic       pending_q, pending_d;
  logic       ssp_clk_q, ssp_clk_d;
  logic [6:0] shift_q, shift_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       frame_q, frame_d;
  logic       din_q, din_d;
  logic [1:0] pcnt_q, pcnt_d;
  logic       pwr_lo_q, pwr_lo_d;
  logic       cl_q, cl_d;
  logic       mod_q, mod_d;
  logic       hyst_q, hyst_d;

  logic div_wrap;
  logic capture;
  logic slot;

  assign div_wrap = (div_q == DIV_MAX);
  assign capture  = div_wrap & ~adc_clk_q;
  // ssp_clk is about to fall: serializer update slot
  assign slot     = ssp_clk_q;

  always_comb begin
    div_d     = div_wrap ? 8'd0 : div_q + 8'd1;
    adc_clk_d = div_wrap ? ~adc_clk_q : adc_clk_q;
    ssp_clk_d = ~ssp_clk_q;
    sample_d  = sample_q;
    pending_d = pending_q;
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    frame_d   = frame_q;
    din_d     = din_q;
    pcnt_d    = pcnt_q;
    pwr_lo_d  = pwr_lo_q;
    cl_d      = cross_lo;
    mod_d     = mod_q;
    hyst_d    = hyst_q;

    // Load sees the old sample; a same-cycle capture stays pending.
    if (slot) begin
      unique case (state_q)
        S_IDLE: begin
          if (pending_q) begin
            shift_d   = sample_q[6:0];
            din_d     = sample_q[7];
            frame_d   = 1'b1;
            bitcnt_d  = 3'd0;
            pending_d = 1'b0;
            state_d   = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bitcnt_q == 3'd7) begin
            frame_d = 1'b0;
            din_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
            din_d    = shift_q[6];
            shift_d  = {shift_q[5:0], 1'b0};
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (capture) begin
      sample_d  = adc_d;
      pending_d = 1'b1;
`ifdef LO_SIM_HYST_EN
      if (adc_d >= TH_SET)
        hyst_d = 1'b1;
      else if (adc_d <= TH_CLR)
        hyst_d = 1'b0;
`endif
    end

    if (!ssp_clk_q) begin
      pcnt_d = pcnt_q + 2'd1;
      if (pcnt_q == 2'd3)
        pwr_lo_d = ~pwr_lo_q;
    end

    if (cross_lo & ~cl_q)
      mod_d = ssp_dout;
  end

  always_ff @(posedge pck0) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= 8'd0;
      adc_clk_q <= 1'b0;
      sample_q  <= 8'd0;
      pending_q <= 1'b0;
      ssp_clk_q <= 1'b0;
      shift_q   <= 7'd0;
      bitcnt_q  <= 3'd0;
      frame_q   <= 1'b0;
      din_q     <= 1'b0;
      pcnt_q    <= 2'd0;
      pwr_lo_q  <= 1'b0;
      cl_q      <= 1'b0;
      mod_q     <= 1'b0;
      hyst_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      adc_clk_q <= adc_clk_d;
      sample_q  <= sample_d;
      pending_q <= pending_d;
      ssp_clk_q <= ssp_clk_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      frame_q   <= frame_d;
      din_q     <= din_d;
      pcnt_q    <= pcnt_d;
      pwr_lo_q  <= pwr_lo_d;
      cl_q      <= cl_d;
      mod_q     <= mod_d;
      hyst_q    <= hyst_d;
    end
  end

  assign adc_clk   = adc_clk_q;
  assign ssp_clk   = ssp_clk_q;
  assign ssp_frame = frame_q;
  assign ssp_din   = din_q;
  assign pwr_lo    = pwr_lo_q;
  assign pwr_hi    = 1'b0;
  assign pwr_oe1   = mod_q;
  assign pwr_oe2   = mod_q;
  assign pwr_oe3   = 1'b0;
  assign pwr_oe4   = mod_q;

  logic unused_sig;
`ifdef LO_SIM_HYST_EN
  assign dbg = hyst_q;
  assign unused_sig = ^{ck_1356meg, ck_1356megb, cross_hi};
`else
  assign dbg = adc_clk_q;
  assign unused_sig = ^{ck_1356meg, ck_1356megb, cross_hi,
                        TH_SET, TH_CLR, hyst_q};
`endif

endmodule

// File: tb/tb_lo_simulate_core.sv
// Randomized bench for lo_simulate_core against a cycle-count based model.
// Model derives clocks from edges since reset and frames from an event log.
module tb_lo_simulate_core;

  logic       pck0 = 1'b0;
  logic       rst = 1'b1;
  logic       ck_1356meg = 1'b0;
  logic       ck_1356megb = 1'b0;
  logic [7:0] adc_d = 8'd0;
  logic       ssp_dout = 1'b0;
  logic       cross_hi = 1'b0;
  logic       cross_lo = 1'b0;
  logic       adc_clk, ssp_frame, ssp_din, ssp_clk;
  logic       pwr_lo, pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4, dbg;

  lo_simulate_core dut (
    .pck0(pck0), .rst(rst),
    .ck_1356meg(ck_1356meg), .ck_1356megb(ck_1356megb),
    .adc_d(adc_d), .ssp_dout(ssp_dout),
    .cross_hi(cross_hi), .cross_lo(cross_lo),
    .adc_clk(adc_clk), .ssp_frame(ssp_frame),
    .ssp_din(ssp_din), .ssp_clk(ssp_clk),
    .pwr_lo(pwr_lo), .pwr_hi(pwr_hi),
    .pwr_oe1(pwr_oe1), .pwr_oe2(pwr_oe2),
    .pwr_oe3(pwr_oe3), .pwr_oe4(pwr_oe4),
    .dbg(dbg)
  );

  always #5 pck0 = ~pck0;

  int checks = 0;
  int errors = 0;

  // model state
  int         n;
  int         next_free;
  int         fstart;
  bit         have;
  bit         pending;
  logic [7:0] pend_val;
  logic [7:0] fbyte;
  bit         prev_cl;
  bit         mod_m;
  bit         hyst_m;

  logic [7:0] pool [8];

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)",
               tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    next_free = 0;
    fstart = 0;
    have = 0;
    pending = 0;
    pend_val = 8'd0;
    fbyte = 8'd0;
    prev_cl = 0;
    mod_m = 0;
    hyst_m = 0;
  endtask

  task automatic model_edge();
    n++;
    // serializer slots are the even edges; load before capture
    if ((n % 2 == 0) && n >= next_free && pending) begin
      fstart = n;
      fbyte = pend_val;
      have = 1;
      pending = 0;
      next_free = n + 18;
    end
    if (n % 12 == 6) begin
      pend_val = adc_d;
      pending = 1;
      if (adc_d >= 8'd200) hyst_m = 1;
      else if (adc_d <= 8'd55) hyst_m = 0;
    end
    if (cross_lo && !prev_cl) mod_m = ssp_dout;
    prev_cl = cross_lo;
  endtask

  function automatic bit exp_frame();
    return have && (n - fstart) < 16;
  endfunction

  function automatic bit exp_din();
    int idx;
    if (!exp_frame()) return 1'b0;
    idx = 7 - (n - fstart) / 2;
    return fbyte[idx];
  endfunction

  task automatic check_outputs();
    bit e_adc;
    e_adc = ((n / 6) % 2) == 1;
    chk("adc_clk", {7'd0, adc_clk}, {7'd0, e_adc});
    chk("ssp_clk", {7'd0, ssp_clk}, 8'(n % 2));
    chk("pwr_lo", {7'd0, pwr_lo}, 8'(((n + 1) / 8) % 2));
    chk("ssp_frame", {7'd0, ssp_frame}, {7'd0, exp_frame()});
    chk("ssp_din", {7'd0, ssp_din}, {7'd0, exp_din()});
    chk("pwr_oe1", {7'd0, pwr_oe1}, {7'd0, mod_m});
    chk("pwr_oe2", {7'd0, pwr_oe2}, {7'd0, mod_m});
    chk("pwr_oe4", {7'd0, pwr_oe4}, {7'd0, mod_m});
    chk("pwr_oe3", {7'd0, pwr_oe3}, 8'd0);
    chk("pwr_hi", {7'd0, pwr_hi}, 8'd0);
`ifdef LO_SIM_HYST_EN
    chk("dbg", {7'd0, dbg}, {7'd0, hyst_m});
`else
    chk("dbg", {7'd0, dbg}, {7'd0, e_adc});
`endif
  endtask

  task automatic step(input bit r);
    rst = r;
    @(posedge pck0);
    #1;
    if (r) model_reset();
    else model_edge();
    check_outputs();
  endtask

  task automatic rand_inputs();
    if ($urandom_range(0, 1) == 1)
      adc_d = pool[$urandom_range(0, 7)];
    else
      adc_d = 8'($urandom);
    ssp_dout = 1'($urandom);
    if ($urandom_range(0, 29) == 0) cross_lo = ~cross_lo;
    ck_1356meg = 1'($urandom);
    ck_1356megb = 1'($urandom);
    cross_hi = 1'($urandom);
  endtask

  initial begin
    bit hit;
    pool[0] = 8'd210; pool[1] = 8'd100;
    pool[2] = 8'd40;  pool[3] = 8'd200;
    pool[4] = 8'd199; pool[5] = 8'd55;
    pool[6] = 8'd56;  pool[7] = 8'hA5;
    model_reset();
    #2;
    repeat (3) step(1'b1);

    // fixed A5 stream first
    adc_d = 8'hA5;
    repeat (120) step(1'b0);

    for (int i = 0; i < 2500; i++) begin
      rand_inputs();
      step(1'b0);
    end

    // reset after bit 3 of a frame has been presented
    for (int k = 0; k < 4; k++) begin
      hit = 0;
      for (int i = 0; i < 300 && !hit; i++) begin
        rand_inputs();
        if (have && (n - fstart) == 10) begin
          hit = 1;
          step(1'b1);
        end else begin
          step(1'b0);
        end
      end
      chk("midframe_found", {7'd0, hit}, 8'd1);
      for (int i = 0; i < 200; i++) begin
        rand_inputs();
        step(1'b0);
      end
    end

    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      step($urandom_range(0, 399) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
